// File: rtl/uart_sched_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_GAP,
        ST_END
    } state_t;

    typedef enum logic [0:0] {
        RET_DATA,
        RET_END
    } ret_t;

    localparam int unsigned HDR_BASE_DEF = 32'hA0;
    localparam int          MAX_LEN_DEF  = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    logic [IW:0] k;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = '0;
        for (int off = 0; off < N; off++) begin
            k = {1'b0, ptr} + (IW+1)'(off);
            if (k >= (IW+1)'(N)) begin
                k = k - (IW+1)'(N);
            end
            if (!any && req[k[IW-1:0]]) begin
                any              = 1'b1;
                grant[k[IW-1:0]] = 1'b1;
                idx              = k[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among N_REQ byte streams, one whole packet per grant,
// with an optional source-ID header byte ahead of each payload.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int          N_REQ    = 4,
    parameter int          D_BITS   = 8,
    parameter int          MAX_LEN  = MAX_LEN_DEF,
    parameter bit          HDR_EN   = 1'b1,
    parameter int unsigned HDR_BASE = HDR_BASE_DEF
) (
    input  logic                    i_clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ*D_BITS-1:0] i_req_data,
    input  logic [N_REQ-1:0]        i_req_last,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic [D_BITS-1:0]       o_tx_data,
    output logic                    o_tx_enable,
    input  logic                    i_tx_rdy,
    output logic [N_REQ-1:0]        o_grant,
    output logic                    o_busy,
    output logic                    o_trunc
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_LEN + 1);

    state_t            state;
    ret_t              ret;
    logic [IW-1:0]     g_idx;
    logic [IW-1:0]     ptr;
    logic [CW-1:0]     count;
    logic              cut;

    logic [N_REQ-1:0]  arb_grant;
    logic [IW-1:0]     arb_idx;
    logic              arb_any;

    logic [D_BITS-1:0] req_byte [N_REQ];
    logic [D_BITS-1:0] cur_byte;
    logic [D_BITS-1:0] hdr_byte;
    logic              cur_valid;
    logic              cur_last;
    logic              take;
    logic [CW-1:0]     count_nx;

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign req_byte[k] = i_req_data[k*D_BITS +: D_BITS];
    end

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req   (i_req_valid),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign cur_byte  = req_byte[g_idx];
    assign cur_valid = i_req_valid[g_idx];
    assign cur_last  = i_req_last[g_idx];
    assign hdr_byte  = D_BITS'(HDR_BASE + 32'(g_idx));
    assign count_nx  = count + CW'(1);

    // A byte is only pulled while the UART is idle, so it is never left stranded.
    assign take        = (state == ST_DATA) && i_tx_rdy && cur_valid;
    assign o_req_ready = take ? o_grant : '0;

    always_ff @(posedge i_clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            ret         <= RET_DATA;
            g_idx       <= '0;
            ptr         <= '0;
            count       <= '0;
            cut         <= 1'b0;
            o_tx_data   <= '0;
            o_tx_enable <= 1'b0;
            o_grant     <= '0;
            o_busy      <= 1'b0;
            o_trunc     <= 1'b0;
        end else begin
            o_tx_enable <= 1'b0;
            o_trunc     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        o_grant <= arb_grant;
                        g_idx   <= arb_idx;
                        o_busy  <= 1'b1;
                        state   <= HDR_EN ? ST_HDR : ST_DATA;
                    end
                end
                ST_HDR: begin
                    if (i_tx_rdy) begin
                        o_tx_data   <= hdr_byte;
                        o_tx_enable <= 1'b1;
                        ret         <= RET_DATA;
                        state       <= ST_GAP;
                    end
                end
                ST_DATA: begin
                    if (take) begin
                        o_tx_data   <= cur_byte;
                        o_tx_enable <= 1'b1;
                        count       <= count_nx;
                        state       <= ST_GAP;
                        if (cur_last || count_nx == CW'(MAX_LEN)) begin
                            ret <= RET_END;
                            cut <= !cur_last;
                        end else begin
                            ret <= RET_DATA;
                        end
                    end
                end
                // GAP gives the UART one cycle to drop its ready after the strobe.
                ST_GAP: begin
                    state   <= (ret == RET_END) ? ST_END : ST_DATA;
                    o_trunc <= (ret == RET_END) && cut;
                end
                ST_END: begin
                    o_grant <= '0;
                    o_busy  <= 1'b0;
                    count   <= '0;
                    cut     <= 1'b0;
                    ptr     <= (g_idx == IW'(N_REQ - 1)) ? '0 : g_idx + IW'(1);
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: a packet-level round-robin model predicts the UART byte stream.
module tb_uart_tx_sched;

    localparam int N  = 4;
    localparam int DB = 8;
    localparam int ML = 16;
    localparam int HB = 'hA0;

    typedef struct packed {
        logic [3:0] grant;
        logic [7:0] data;
    } exp_t;

    logic            clk;
    logic            reset;
    logic [N-1:0]    i_req_valid;
    logic [N*DB-1:0] i_req_data;
    logic [N-1:0]    i_req_last;
    logic [N-1:0]    o_req_ready;
    logic [DB-1:0]   o_tx_data;
    logic            o_tx_enable;
    logic            i_tx_rdy;
    logic [N-1:0]    o_grant;
    logic            o_busy;
    logic            o_trunc;

    exp_t       expq [$];
    logic [8:0] drv_q [N][$];
    logic [8:0] mq [N][$];
    int         pops [N];
    logic [N-1:0] vmask;
    bit         hold_rdy;
    bit         en_seen;
    int         busy_cnt;
    int         n_checks;
    int         n_pass;
    int         trunc_seen;
    int         exp_trunc;
    int         model_ptr;
    logic       prev_en;
    logic       prev_rdy;
    logic       prev_trunc;

    uart_tx_sched #(
        .N_REQ    (N),
        .D_BITS   (DB),
        .MAX_LEN  (ML),
        .HDR_EN   (1'b1),
        .HDR_BASE (HB)
    ) dut (
        .i_clk       (clk),
        .reset       (reset),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .i_req_last  (i_req_last),
        .o_req_ready (o_req_ready),
        .o_tx_data   (o_tx_data),
        .o_tx_enable (o_tx_enable),
        .i_tx_rdy    (i_tx_rdy),
        .o_grant     (o_grant),
        .o_busy      (o_busy),
        .o_trunc     (o_trunc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Packet-level reference: strict rotation over non-empty queues, header then payload
    // until last or ML bytes; an unfinished packet stalls the stream.
    task automatic model_run();
        bit   stop;
        int   w;
        int   k;
        int   n;
        bit   done;
        logic [8:0] b;
        exp_t e;
        stop = 0;
        while (!stop) begin
            w = -1;
            for (int off = 0; off < N; off++) begin
                k = (model_ptr + off) % N;
                if (w < 0 && mq[k].size() > 0) w = k;
            end
            if (w < 0) begin
                stop = 1;
            end else begin
                e.grant = 4'(1 << w);
                e.data  = 8'((HB + w) % 256);
                expq.push_back(e);
                n = 0;
                done = 0;
                while (!done && mq[w].size() > 0) begin
                    b = mq[w].pop_front();
                    e.data = b[7:0];
                    expq.push_back(e);
                    n++;
                    if (b[8]) done = 1;
                    else if (n == ML) begin
                        done = 1;
                        exp_trunc++;
                    end
                end
                if (!done) stop = 1;
                else model_ptr = (w + 1) % N;
            end
        end
    endtask

    task automatic push_byte(input int k, input logic [7:0] d, input logic last, input bit to_model);
        drv_q[k].push_back({last, d});
        if (to_model) mq[k].push_back({last, d});
    endtask

    task automatic push_pkt(input int k, input int len);
        for (int i = 0; i < len; i++) begin
            push_byte(k, 8'($urandom_range(0, 255)), (i == len - 1), 1'b1);
        end
    endtask

    function automatic bit drv_empty();
        bit e;
        e = 1;
        for (int k = 0; k < N; k++) if (drv_q[k].size() != 0) e = 0;
        return e;
    endfunction

    task automatic wait_done(input string name);
        int cyc;
        bit done;
        cyc = 0;
        done = 0;
        while (!done && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            done = (expq.size() == 0) && !o_busy && drv_empty();
        end
        check({name, "_done"}, 32'(done), 32'(1));
        check({name, "_trunc_count"}, 32'(trunc_seen), 32'(exp_trunc));
    endtask

    task automatic wait_pops(input int k, input int target, input string name);
        int cyc;
        cyc = 0;
        while (pops[k] < target && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check(name, 32'(pops[k] >= target), 32'(1));
    endtask

    // Requester driver: pops a byte whenever the DUT showed ready for it.
    initial begin
        logic [N-1:0] snap;
        i_req_valid = '0;
        i_req_data  = '0;
        i_req_last  = '0;
        forever begin
            @(negedge clk);
            snap = o_req_ready;
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (snap[k] && drv_q[k].size() > 0) begin
                    void'(drv_q[k].pop_front());
                    pops[k]++;
                end
                i_req_valid[k] = (drv_q[k].size() > 0) && !vmask[k];
                i_req_data[k*DB +: DB] = (drv_q[k].size() > 0) ? drv_q[k][0][7:0] : 8'h00;
                i_req_last[k] = (drv_q[k].size() > 0) ? drv_q[k][0][8] : 1'b0;
            end
        end
    end

    // UART model: ready drops the cycle after each strobe and stays low 1..4 cycles.
    initial begin
        i_tx_rdy = 1'b1;
        busy_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (en_seen) busy_cnt = $urandom_range(1, 4);
            else if (busy_cnt > 0) busy_cnt--;
            i_tx_rdy = (busy_cnt == 0) && !hold_rdy;
        end
    end

    // Monitor: pops the scoreboard on every strobe and checks handshake rules.
    initial begin
        exp_t e;
        prev_en = 1'b0;
        prev_rdy = 1'b0;
        prev_trunc = 1'b0;
        forever begin
            @(negedge clk);
            en_seen = o_tx_enable;
            if (o_tx_enable) begin
                check("tx_spacing_and_rdy", 32'({prev_en, prev_rdy}), 32'(2'b01));
                check("tx_expected_present", 32'(expq.size() != 0), 32'(1));
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    check("tx_grant_byte", 32'({o_grant, o_tx_data}), 32'({e.grant, e.data}));
                end
            end
            if (o_req_ready != '0) begin
                check("ready_legal", 32'({i_tx_rdy, o_req_ready}), 32'({1'b1, o_grant & i_req_valid}));
            end
            if (o_trunc) begin
                trunc_seen++;
                check("trunc_single_cycle", 32'(prev_trunc), 32'(0));
            end
            prev_en = o_tx_enable;
            prev_rdy = i_tx_rdy;
            prev_trunc = o_trunc;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int viol;
        int p0;
        logic [7:0] rest [3];
        reset = 1'b1;
        hold_rdy = 1'b0;
        vmask = '0;
        n_checks = 0;
        n_pass = 0;
        trunc_seen = 0;
        exp_trunc = 0;
        model_ptr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", 32'(o_grant), 32'(0));
        check("rst_busy", 32'(o_busy), 32'(0));
        check("rst_tx_enable", 32'(o_tx_enable), 32'(0));
        check("rst_tx_data", 32'(o_tx_data), 32'(0));
        check("rst_trunc", 32'(o_trunc), 32'(0));
        check("rst_ready", 32'(o_req_ready), 32'(0));
        reset = 1'b0;

        // Single requester 1: header A1 then 11, 22.
        push_byte(1, 8'h11, 1'b0, 1'b1);
        push_byte(1, 8'h22, 1'b1, 1'b1);
        model_run();
        wait_done("t1");
        check("t1_pointer", 32'(dut.ptr), 32'(model_ptr));

        // Reset to pointer 0, then requesters 0 and 2 together.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_ptr = 0;
        push_pkt(0, 3);
        push_pkt(2, 2);
        model_run();
        wait_done("t2");

        // Requester 3 sends 20 bytes with no last until the end; requester 0 competes.
        for (int i = 0; i < 20; i++) push_byte(3, 8'(8'h30 + i), (i == 19), 1'b1);
        push_pkt(0, 3);
        model_run();
        wait_done("t3");

        // UART held busy for 50 cycles with requester 0 waiting.
        hold_rdy = 1'b1;
        repeat (3) @(negedge clk);
        push_byte(0, 8'h5A, 1'b1, 1'b1);
        model_run();
        viol = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (o_tx_enable || o_req_ready != '0) viol++;
        end
        check("t4_quiet_while_not_ready", 32'(viol), 32'(0));
        check("t4_grant_held", 32'(o_grant), 32'(4'b0001));
        hold_rdy = 1'b0;
        @(negedge clk);
        check("t4_no_early_strobe", 32'(o_tx_enable), 32'(0));
        @(negedge clk);
        check("t4_strobe_after_rdy", 32'(o_tx_enable), 32'(1));
        wait_done("t4");

        // Granted requester 2 drops valid for 10 cycles mid-packet.
        p0 = pops[2];
        push_pkt(2, 6);
        model_run();
        wait_pops(2, p0 + 2, "t5_two_bytes_taken");
        vmask[2] = 1'b1;
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 3 && o_tx_enable) viol++;
            if (o_grant != 4'b0100) viol++;
        end
        check("t5_grant_held_no_strobe", 32'(viol), 32'(0));
        vmask[2] = 1'b0;
        wait_done("t5");

        // Reset in DATA after 3 bytes of requester 1; remaining bytes stay queued.
        p0 = pops[1];
        for (int i = 0; i < 3; i++) push_byte(1, 8'(8'hC0 + i), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            rest[i] = 8'(8'hD0 + i);
            push_byte(1, rest[i], (i == 2), 1'b0);
        end
        model_run();
        wait_pops(1, p0 + 3, "t6_three_bytes_taken");
        hold_rdy = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_pre_reset_flushed", 32'(expq.size()), 32'(0));
        reset = 1'b1;
        push_pkt(3, 2);
        @(negedge clk);
        check("t6_rst_grant", 32'(o_grant), 32'(0));
        check("t6_rst_busy", 32'(o_busy), 32'(0));
        check("t6_rst_enable", 32'(o_tx_enable), 32'(0));
        check("t6_rst_data", 32'(o_tx_data), 32'(0));
        check("t6_rst_pointer", 32'(dut.ptr), 32'(0));
        check("t6_fourth_not_taken", 32'(pops[1]), 32'(p0 + 3));
        reset = 1'b0;
        hold_rdy = 1'b0;
        for (int i = 0; i < 3; i++) mq[1].push_back({(i == 2), rest[i]});
        model_ptr = 0;
        model_run();
        wait_done("t6");

        // Randomized rounds of concurrent packets.
        for (int r = 0; r < 6; r++) begin
            bit any;
            any = 0;
            for (int k = 0; k < N; k++) begin
                int npk;
                npk = $urandom_range(0, 2);
                for (int p = 0; p < npk; p++) begin
                    push_pkt(k, $urandom_range(1, 20));
                    any = 1;
                end
            end
            if (!any) push_pkt(r % N, $urandom_range(1, 20));
            model_run();
            wait_done($sformatf("rnd%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
